// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencer time-sharing one ALU and one memory port.
// In: clk, rst_n, opcode, mem_ack. Out: datapath strobes, illegal, bus_err, state, retired.
module multicycle_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t     cur, nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       retire, set_ill, set_berr;
  logic       timeout;
  logic       is_r, is_i, is_ld, is_st;
  logic       is_br, is_j, is_ill;

  assign is_r   = (opcode == 6'd0);
  assign is_i   = (opcode >= 6'd1) && (opcode <= 6'd5);
  assign is_ld  = (opcode == 6'd6);
  assign is_st  = (opcode == 6'd7);
  assign is_br  = (opcode >= 6'd8) && (opcode <= 6'd13);
  assign is_j   = (opcode >= 6'd14) && (opcode <= 6'd16);
  assign is_ill = (opcode >= 6'd17);

  // Last permitted waiting cycle; an ack here still wins.
  assign timeout = (wcnt == 8'(MAX_WAIT - 1));

  assign state = cur;

  always_comb begin
    nxt           = cur;
    retire        = 1'b0;
    set_ill       = 1'b0;
    set_berr      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    unique case (cur)
      IDLE: nxt = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'd1;
          nxt       = DECODE;
        end else if (timeout) begin
          nxt      = HALT;
          set_berr = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = 2'd3;
        if (is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          alu_op   = 2'd2;
          retire   = 1'b1;
          nxt      = FETCH;
        end else if (is_ill) begin
          set_ill = 1'b1;
          nxt     = HALT;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        unique case (1'b1)
          is_r: begin
            alu_op = 2'd3;
            nxt    = WB;
          end
          is_i, is_ld, is_st: begin
            alu_src_b = 2'd2;
            alu_op    = 2'd1;
            nxt       = is_i ? WB : MEM;
          end
          is_br: begin
            pc_write_cond = 1'b1;
            pc_src        = 2'd1;
            retire        = 1'b1;
            nxt           = FETCH;
          end
          default: begin
            set_ill = 1'b1;
            nxt     = HALT;
          end
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_st;
        if (mem_ack) begin
          retire = is_st;
          nxt    = is_st ? FETCH : WB;
        end else if (timeout) begin
          nxt      = HALT;
          set_berr = 1'b1;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_ld;
        retire     = 1'b1;
        nxt        = FETCH;
      end
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // Counts only while holding in FETCH/MEM; any exit or ack clears it.
  always_comb begin
    wcnt_nxt = 8'd0;
    if ((cur == FETCH || cur == MEM) && nxt == cur)
      wcnt_nxt = wcnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= IDLE;
      wcnt    <= 8'd0;
      retired <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      cur  <= nxt;
      wcnt <= wcnt_nxt;
      if (retire)
        retired <= retired + CNT_W'(1);
      if (set_ill)
        illegal <= 1'b1;
      if (set_berr)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + random checks against an instruction-path model.
// Drives opcode/mem_ack per cycle and compares every output each cycle.
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, iord, ir_write;
  logic          pc_write, pc_write_cond, alu_src_a;
  logic          reg_dst, mem_to_reg, reg_write;
  logic          illegal, bus_err;
  logic [1:0]    pc_src, alu_src_b, alu_op;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .bus_err(bus_err), .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [24:0] dvec;
  assign dvec = {mem_req, mem_we, iord, ir_write, pc_write,
                 pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_op,
                 reg_dst, mem_to_reg, reg_write,
                 illegal, bus_err, state, retired};

  int vecs = 0;
  int errs = 0;

  typedef int path_t[$];

  // Model: phase numbers follow the debug state numbering.
  int    m_ph, m_op, m_step, m_wait, m_ret;
  bit    m_ill, m_berr;
  path_t m_path;

  function automatic int cls(input int op);
    if (op == 0) return 0;
    if (op <= 5) return 1;
    if (op == 6) return 2;
    if (op == 7) return 3;
    if (op <= 13) return 4;
    if (op <= 16) return 5;
    return 6;
  endfunction

  // Sequence of phases an instruction walks through.
  function automatic path_t path_of(input int c);
    path_t p;
    case (c)
      0, 1: p = '{1, 2, 3, 5};
      2: p = '{1, 2, 3, 4, 5};
      3: p = '{1, 2, 3, 4};
      4: p = '{1, 2, 3};
      5: p = '{1, 2};
      default: p = '{1, 2, 6};
    endcase
    return p;
  endfunction

  function automatic logic [24:0] expect_vec(input int ph, input int op,
                                             input bit ack);
    logic mreq, mwe, io, irw, pcw, pcwc, asa, rdst, m2r, rw;
    logic [1:0] psrc, asb, aop;
    {mreq, mwe, io, irw, pcw, pcwc, asa, rdst, m2r, rw} = '0;
    psrc = 2'd0; asb = 2'd0; aop = 2'd0;
    case (ph)
      1: begin
        mreq = 1'b1;
        if (ack) begin irw = 1'b1; pcw = 1'b1; asb = 2'd1; end
      end
      2: begin
        asb = 2'd3;
        if (cls(op) == 5) begin pcw = 1'b1; psrc = 2'd2; aop = 2'd2; end
      end
      3: begin
        asa = 1'b1;
        case (cls(op))
          0: aop = 2'd3;
          1, 2, 3: begin asb = 2'd2; aop = 2'd1; end
          4: begin pcwc = 1'b1; psrc = 2'd1; end
          default: ;
        endcase
      end
      4: begin mreq = 1'b1; io = 1'b1; mwe = (op == 7); end
      5: begin rw = 1'b1; rdst = (op == 0); m2r = (op == 6); end
      default: ;
    endcase
    return {mreq, mwe, io, irw, pcw, pcwc, psrc, asa, asb, aop,
            rdst, m2r, rw, m_ill, m_berr, 3'(ph), CW'(m_ret)};
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_op = 0; m_step = 0; m_wait = 0;
    m_ret = 0; m_ill = 1'b0; m_berr = 1'b0;
    m_path = '{1, 2};
  endfunction

  function automatic void model_clock(input int op, input bit ack);
    if (m_ph == 6) return;
    if (m_ph == 0) begin
      m_ph = 1; m_step = 0; m_wait = 0; m_path = '{1, 2};
      return;
    end
    if ((m_ph == 1 || m_ph == 4) && !ack) begin
      m_wait++;
      if (m_wait == MW) begin m_ph = 6; m_berr = 1'b1; end
      return;
    end
    if (m_ph == 2) begin m_op = op; m_path = path_of(cls(op)); end
    m_step++;
    m_wait = 0;
    if (m_step >= m_path.size()) begin
      m_ret = (m_ret + 1) % (1 << CW);
      m_ph = 1; m_step = 0; m_path = '{1, 2};
    end else begin
      m_ph = m_path[m_step];
      if (m_ph == 6) m_ill = 1'b1;
    end
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // One clock cycle: drive, compare all outputs, clock the model.
  task automatic step(input logic [5:0] op, input bit ack);
    logic [24:0] e;
    opcode = op;
    mem_ack = ack;
    #2;
    e = expect_vec(m_ph, (m_ph == 2) ? int'(op) : m_op, ack);
    vecs++;
    if (dvec !== e) begin
      errs++;
      $display("FAIL cycle ph=%0d op=%0d ack=%0d dut=%h exp=%h",
               m_ph, op, ack, dvec, e);
    end
    @(posedge clk);
    model_clock(int'(op), ack);
    #1;
  endtask

  // Leaves the bench in the IDLE cycle, ready for step().
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #3;
    model_reset();
    chk("reset_zero", int'(dvec), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input int op);
    int r0;
    int n;
    r0 = m_ret;
    n = 0;
    while (m_ret == r0 && m_ph != 6 && n < 12) begin
      step(6'(op), 1'b1);
      n++;
    end
    if (n >= 12) begin
      vecs++; errs++;
      $display("FAIL run_op bound op=%0d", op);
    end
  endtask

  initial begin
    int iop;
    int hcnt;
    bit slow;
    bit a;
    logic [5:0] o;
    model_reset();

    // R-type zero wait: 0,1,2,3,5,1
    do_reset();
    step(6'd0, 1'b1); chk("r_st1", state, 1);
    step(6'd0, 1'b1); chk("r_st2", state, 2);
    step(6'd0, 1'b1); chk("r_st3", state, 3);
    chk("r_aluop", alu_op, 3);
    step(6'd0, 1'b1); chk("r_st5", state, 5);
    chk("r_wb", {reg_write, reg_dst}, 3);
    step(6'd0, 1'b1); chk("r_st1b", state, 1);
    chk("r_ret", retired, 1);

    // Load with three wait cycles in MEM.
    do_reset();
    step(6'd33, 1'b0);
    step(6'd33, 1'b1);
    step(6'd6, 1'b1);
    step(6'd6, 1'b1);
    chk("ld_mem", {mem_req, iord, mem_we, 5'(state)}, 8'hC4);
    step(6'd6, 1'b0);
    step(6'd6, 1'b0);
    step(6'd6, 1'b0);
    step(6'd6, 1'b1);
    chk("ld_wb", {mem_to_reg, 3'(state)}, 4'hD);
    step(6'd6, 1'b1);
    chk("ld_ret", retired, 1);

    // Store, branch, jump.
    do_reset();
    step(6'd0, 1'b1);
    run_op(7);
    run_op(9);
    run_op(15);
    chk("sbj_ret", retired, 3);
    chk("sbj_st", state, 1);

    // Illegal opcode halts until reset.
    do_reset();
    step(6'd0, 1'b1);
    step(6'd0, 1'b1);
    step(6'd20, 1'b1);
    for (int i = 0; i < 20; i++)
      step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    chk("ill_flag", illegal, 1);
    chk("ill_st", state, 6);
    do_reset();
    chk("ill_clr", {illegal, 3'(state)}, 0);

    // Fetch timeout and last-cycle ack.
    step(6'd0, 1'b0);
    for (int i = 0; i < 14; i++) step(6'd0, 1'b0);
    chk("to_pre", {bus_err, 3'(state)}, 1);
    step(6'd0, 1'b0);
    chk("to_halt", {bus_err, 3'(state)}, 4'hE);
    do_reset();
    step(6'd0, 1'b0);
    for (int i = 0; i < 14; i++) step(6'd0, 1'b0);
    step(6'd0, 1'b1);
    chk("to_ack", {bus_err, 3'(state)}, 2);

    // Counter wrap with 17 jumps.
    do_reset();
    step(6'd0, 1'b1);
    for (int i = 0; i < 17; i++) run_op(14 + (i % 3));
    chk("wrap_ret", retired, 1);

    // Async reset mid-MEM.
    do_reset();
    step(6'd0, 1'b1);
    run_op(7);
    step(6'd0, 1'b1);
    step(6'd6, 1'b1);
    step(6'd6, 1'b1);
    mem_ack = 1'b0;
    #1;
    chk("mid_req", {mem_req, 3'(state)}, 4'hC);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {mem_req, 3'(state), 4'(retired)}, 0);
    do_reset();

    // Random traffic.
    iop = 0;
    hcnt = 0;
    slow = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (hcnt > 6 || $urandom_range(0, 599) == 0) begin
        do_reset();
        hcnt = 0;
        slow = ($urandom_range(0, 3) == 0);
      end
      if (m_ph == 1)
        iop = ($urandom_range(0, 39) == 0) ? int'($urandom_range(17, 63))
                                           : int'($urandom_range(0, 16));
      if (m_ph >= 2 && m_ph <= 5) o = 6'(iop);
      else o = 6'($urandom_range(0, 63));
      if (m_ph == 1 || m_ph == 4)
        a = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
      else
        a = 1'($urandom_range(0, 1));
      step(o, a);
      if (m_ph == 6) hcnt++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
